if_id_reg: RTL and testbench
============================

Name: if_id_reg

Overview:
- IF/ID pipeline register of the five-stage RV32I pipeline.
- Captures the fetched PC and instruction, and pre-decodes the instruction into the register fields, the 25-bit immediate field and the 3-bit immediate-type select consumed by the immediate generator in ID.
- Supports hazard-unit stall (hold), branch/jump flush (bubble insertion) and a saturating stall-cycle counter for debug.

Parameters:
- XLEN, 32, datapath width for PC and instruction.
- NOP_INSTR, 32'h00000013, encoding injected on flush and reset (addi x0,x0,0).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  PC of the fetched instruction.
- if_instr  in  XLEN  fetched instruction word.
- if_valid  in  1  fetch output is a real instruction.
- stall  in  1  hazard unit: hold current contents.
- flush  in  1  control redirect: replace contents with bubble.
- id_pc  out  XLEN  registered PC.
- id_pc4  out  XLEN  registered PC+4, modulo 2^32.
- id_instr  out  XLEN  registered instruction.
- id_valid  out  1  registered instruction is real.
- id_opcode  out  7  instr[6:0].
- id_rd  out  5  instr[11:7].
- id_rs1  out  5  instr[19:15].
- id_rs2  out  5  instr[24:20].
- id_funct3  out  3  instr[14:12].
- id_immediate  out  25  instr[31:7]; feeds the immediate generator.
- id_imm_sel  out  3  immediate type: 000 I, 001 S, 010 B, 011 U, 100 J.
- id_has_imm  out  1  instruction carries an immediate.
- id_illegal  out  1  valid instruction with unrecognised opcode.
- id_stall_cycles  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset is asynchronous and active-low: rst_n low forces the reset state immediately, independent of clk.
- Reset state:
  - id_pc = 0, id_pc4 = 4, id_instr = NOP_INSTR, id_valid = 0.
  - id_stall_cycles = 0.
  - Decoded fields are those of NOP_INSTR: opcode 0010011, rd/rs1/rs2 = 0, imm_sel 000, has_imm 1, illegal 0.
- The register is updated on the rising clk edge. Priority is reset > flush > stall > load.
- flush = 1:
  - id_instr <= NOP_INSTR, id_valid <= 0.
  - id_pc and id_pc4 <= if_pc and if_pc+4; these values are don't-care for verification.
  - flush wins over a simultaneous stall.
- stall = 1 and flush = 0:
  - All registers hold.
  - id_stall_cycles increments by 1 and saturates at 2^CNT_W-1, with no wrap.
- Otherwise (load):
  - id_pc <= if_pc, id_pc4 <= if_pc+4, id_instr <= if_instr.
  - id_valid <= if_valid.
  - If if_valid = 0, id_instr <= NOP_INSTR.
- Latency is one cycle from IF inputs to ID outputs.
- Decoded outputs derive from a single decode of the incoming instruction, registered together with it.
  - Either decode before the register or combinationally from id_instr. In both cases the outputs are a pure function of id_instr, so a stall never changes them.
- Immediate-type decode by opcode:
  - 0010011, 0000011, 1100111, 1110011 -> 000, has_imm 1.
  - 0100011 -> 001, has_imm 1.
  - 1100011 -> 010, has_imm 1.
  - 0110111, 0010111 -> 011, has_imm 1.
  - 1101111 -> 100, has_imm 1.
  - 0110011 -> 000, has_imm 0.
  - Any other opcode -> 000, has_imm 0, and id_illegal = id_valid.
- id_illegal is never 1 while id_valid = 0.
- PC+4 wraps: if_pc = 32'hFFFFFFFC gives id_pc4 = 0.
- Reset asserted mid-stall clears the counter and inserts a bubble. Operation resumes on the first edge after rst_n rises.

Decomposition:
- Shared package rv_pkg holds:
  - Opcode constants (OP_IMM, LOAD, JALR, SYSTEM, STORE, BRANCH, LUI, AUIPC, JAL, OP).
  - Immediate-select constants IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_U=3'b011, IMM_J=3'b100. The immediate generator uses the same constants.
  - The NOP_INSTR constant.
- One combinational sub-module, imm_type_dec: input opcode[6:0], outputs imm_sel, has_imm, unknown. It is reusable by later decode logic.

Test Plan:
- Reset: hold rst_n=0 mid-cycle -> outputs change immediately. id_instr=32'h00000013, id_valid=0, id_pc4=4, id_stall_cycles=0.
- Load sw x5,8(x2)=32'h00512423, if_pc=32'h100, valid=1 -> next cycle: id_imm_sel=001, id_immediate=instr[31:7], id_rs1=2, id_rs2=5, id_pc4=32'h104.
- Stall: load jal 32'h008000EF, then stall=1 for 3 cycles with changing if_instr -> outputs frozen (imm_sel=100), id_stall_cycles=3.
- Flush+stall together during beq 32'h00208463 -> next cycle: id_instr=NOP, id_valid=0, id_illegal=0, counter unchanged.
- Illegal opcode 32'hFFFFFFFF, valid=1 -> id_illegal=1, has_imm=0. Same word with if_valid=0 -> id_instr=NOP, id_illegal=0.
- Wrap/saturation:
  - if_pc=32'hFFFFFFFC -> id_pc4=0.
  - With CNT_W=4, hold stall 20 cycles -> id_stall_cycles=15.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: opcodes, immediate-type selects and the bubble encoding.
package rv_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/imm_type_dec.sv
// Opcode -> immediate-type select; flags opcodes outside the supported RV32I set.
module imm_type_dec
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] imm_sel,
    output logic       has_imm,
    output logic       unknown
);

    always_comb begin
        imm_sel = IMM_I;
        has_imm = 1'b1;
        unknown = 1'b0;
        case (opcode)
            OP_IMM, LOAD, JALR, SYSTEM: imm_sel = IMM_I;
            STORE:                      imm_sel = IMM_S;
            BRANCH:                     imm_sel = IMM_B;
            LUI, AUIPC:                 imm_sel = IMM_U;
            JAL:                        imm_sel = IMM_J;
            OP:                         has_imm = 1'b0;
            default: begin
                has_imm = 1'b0;
                unknown = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall hold, flush bubble and a saturating stall counter.
module if_id_reg
    import rv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(rv_pkg::NOP_INSTR),
    parameter int              CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [XLEN-1:0]  if_instr,
    input  logic             if_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  id_pc4,
    output logic [XLEN-1:0]  id_instr,
    output logic             id_valid,
    output logic [6:0]       id_opcode,
    output logic [4:0]       id_rd,
    output logic [4:0]       id_rs1,
    output logic [4:0]       id_rs2,
    output logic [2:0]       id_funct3,
    output logic [24:0]      id_immediate,
    output logic [2:0]       id_imm_sel,
    output logic             id_has_imm,
    output logic             id_illegal,
    output logic [CNT_W-1:0] id_stall_cycles
);

    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  pc4_q, pc4_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unknown;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            pc_d    = if_pc;
            pc4_d   = if_pc + XLEN'(4);
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall) begin
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end else begin
            pc_d    = if_pc;
            pc4_d   = if_pc + XLEN'(4);
            instr_d = if_valid ? if_instr : NOP_INSTR;
            valid_d = if_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            pc4_q   <= XLEN'(4);
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Decode straight off the register so held contents always decode identically.
    imm_type_dec u_imm_type_dec (
        .opcode  (instr_q[6:0]),
        .imm_sel (id_imm_sel),
        .has_imm (id_has_imm),
        .unknown (unknown)
    );

    assign id_pc           = pc_q;
    assign id_pc4          = pc4_q;
    assign id_instr        = instr_q;
    assign id_valid        = valid_q;
    assign id_opcode       = instr_q[6:0];
    assign id_rd           = instr_q[11:7];
    assign id_funct3       = instr_q[14:12];
    assign id_rs1          = instr_q[19:15];
    assign id_rs2          = instr_q[24:20];
    assign id_immediate    = instr_q[31:7];
    assign id_illegal      = valid_q & unknown;
    assign id_stall_cycles = cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Self-checking bench for if_id_reg: directed scenarios plus randomized traffic against a reference model.
module tb_if_id_reg;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic             clk, rst_n;
    logic [31:0]      if_pc, if_instr;
    logic             if_valid, stall, flush;
    logic [31:0]      id_pc, id_pc4, id_instr;
    logic             id_valid;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rd, id_rs1, id_rs2;
    logic [2:0]       id_funct3;
    logic [24:0]      id_immediate;
    logic [2:0]       id_imm_sel;
    logic             id_has_imm, id_illegal;
    logic [CNT_W-1:0] id_stall_cycles;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid, m_pc_known;
    int          m_cnt;

    if_id_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid),
        .stall(stall), .flush(flush),
        .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_funct3(id_funct3), .id_immediate(id_immediate), .id_imm_sel(id_imm_sel),
        .id_has_imm(id_has_imm), .id_illegal(id_illegal), .id_stall_cycles(id_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {imm_sel, has_imm, recognised} straight from the opcode table
    function automatic logic [4:0] ref_imm(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67, 7'h73: return {3'd0, 1'b1, 1'b1};
            7'h23:                      return {3'd1, 1'b1, 1'b1};
            7'h63:                      return {3'd2, 1'b1, 1'b1};
            7'h37, 7'h17:               return {3'd3, 1'b1, 1'b1};
            7'h6F:                      return {3'd4, 1'b1, 1'b1};
            7'h33:                      return {3'd0, 1'b0, 1'b1};
            default:                    return {3'd0, 1'b0, 1'b0};
        endcase
    endfunction

    task automatic model_reset();
        m_pc = 0; m_pc4 = 4; m_instr = NOP; m_valid = 0; m_cnt = 0; m_pc_known = 1;
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input logic s, input logic f);
        if_pc = pc; if_instr = ins; if_valid = v; stall = s; flush = f;
        @(posedge clk);
        if (f) begin
            m_instr = NOP; m_valid = 0; m_pc_known = 0;
        end else if (s) begin
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            m_pc = pc; m_pc4 = pc + 32'd4; m_instr = v ? ins : NOP; m_valid = v; m_pc_known = 1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        cycle(32'h200, 32'h00512423, 1, 0, 0);
        cycle(32'h204, 32'h0, 1, 1, 0);
        cycle(32'h204, 32'h0, 1, 1, 0);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({id_instr, id_valid, id_pc, id_pc4} !== {NOP, 1'b0, 32'h0, 32'h4}) begin
            miscompares++;
            $display("FAIL reset_regs: got instr=%h valid=%b pc=%h pc4=%h, want %h 0 0 4",
                     id_instr, id_valid, id_pc, id_pc4, NOP);
        end
        vectors++;
        if (id_stall_cycles !== '0) begin
            miscompares++;
            $display("FAIL reset_cnt: got %0d want 0", id_stall_cycles);
        end
        vectors++;
        if ({id_opcode, id_rd, id_rs1, id_rs2, id_imm_sel, id_has_imm, id_illegal}
            !== {7'b0010011, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_decode: got op=%b rd=%0d rs1=%0d rs2=%0d sel=%b has=%b ill=%b",
                     id_opcode, id_rd, id_rs1, id_rs2, id_imm_sel, id_has_imm, id_illegal);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        logic [31:0] w;
        w = 32'h00512423;
        cycle(32'h100, w, 1, 0, 0);
        vectors++;
        if ({id_imm_sel, id_immediate, id_rs1, id_rs2, id_pc4, id_valid, id_funct3}
            !== {3'b001, w[31:7], 5'd2, 5'd5, 32'h104, 1'b1, 3'd2}) begin
            miscompares++;
            $display("FAIL store_load: got sel=%b imm=%h rs1=%0d rs2=%0d pc4=%h valid=%b f3=%0d",
                     id_imm_sel, id_immediate, id_rs1, id_rs2, id_pc4, id_valid, id_funct3);
        end
    endtask

    task automatic test_stall();
        cycle(32'h300, 32'h008000EF, 1, 0, 0);
        repeat (3) cycle($urandom, $urandom, 1, 1, 0);
        vectors++;
        if ({id_instr, id_pc, id_imm_sel, id_rd, id_valid} !== {32'h008000EF, 32'h300, 3'b100, 5'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_hold: got instr=%h pc=%h sel=%b rd=%0d valid=%b",
                     id_instr, id_pc, id_imm_sel, id_rd, id_valid);
        end
        vectors++;
        if (id_stall_cycles !== CNT_W'(3)) begin
            miscompares++;
            $display("FAIL stall_count: got %0d want 3", id_stall_cycles);
        end
    endtask

    task automatic test_flush_stall();
        cycle(32'h304, 32'h00208463, 1, 0, 0);
        vectors++;
        if (id_imm_sel !== 3'b010) begin
            miscompares++;
            $display("FAIL beq_sel: got %b want 010", id_imm_sel);
        end
        cycle(32'h308, $urandom, 1, 1, 1);
        vectors++;
        if ({id_instr, id_valid, id_illegal, id_stall_cycles} !== {NOP, 1'b0, 1'b0, CNT_W'(3)}) begin
            miscompares++;
            $display("FAIL flush_stall: got instr=%h valid=%b ill=%b cnt=%0d, want %h 0 0 3",
                     id_instr, id_valid, id_illegal, id_stall_cycles, NOP);
        end
    endtask

    task automatic test_illegal();
        cycle(32'h400, 32'hFFFFFFFF, 1, 0, 0);
        vectors++;
        if ({id_illegal, id_has_imm, id_imm_sel} !== {1'b1, 1'b0, 3'b000}) begin
            miscompares++;
            $display("FAIL illegal_valid: got ill=%b has=%b sel=%b, want 1 0 000",
                     id_illegal, id_has_imm, id_imm_sel);
        end
        cycle(32'h404, 32'hFFFFFFFF, 0, 0, 0);
        vectors++;
        if ({id_instr, id_illegal, id_valid} !== {NOP, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL illegal_invalid: got instr=%h ill=%b valid=%b", id_instr, id_illegal, id_valid);
        end
    endtask

    task automatic test_wrap();
        cycle(32'hFFFFFFFC, 32'h00000033, 1, 0, 0);
        vectors++;
        if ({id_pc, id_pc4, id_has_imm} !== {32'hFFFFFFFC, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL pc4_wrap: got pc=%h pc4=%h has=%b, want fffffffc 0 0", id_pc, id_pc4, id_has_imm);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (14) cycle($urandom, $urandom, 1, 1, 0);
        vectors++;
        if (id_stall_cycles !== CNT_W'(14)) begin
            miscompares++;
            $display("FAIL sat_below: got %0d want 14", id_stall_cycles);
        end
        repeat (6) cycle($urandom, $urandom, 1, 1, 0);
        vectors++;
        if (id_stall_cycles !== CNT_W'(CMAX)) begin
            miscompares++;
            $display("FAIL sat_hold: got %0d want %0d", id_stall_cycles, CMAX);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        cycle(32'h500, 32'h00A00093, 1, 0, 0);
        repeat (2) cycle($urandom, $urandom, 1, 1, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({id_stall_cycles, id_valid, id_instr} !== {CNT_W'(0), 1'b0, NOP}) begin
            miscompares++;
            $display("FAIL reset_mid_stall: got cnt=%0d valid=%b instr=%h", id_stall_cycles, id_valid, id_instr);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(32'h600, 32'h00C00113, 1, 0, 0);
        vectors++;
        if ({id_instr, id_valid, id_pc} !== {32'h00C00113, 1'b1, 32'h600}) begin
            miscompares++;
            $display("FAIL resume_after_reset: got instr=%h valid=%b pc=%h", id_instr, id_valid, id_pc);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [11];
        logic [31:0] ins, r;
        logic [4:0]  d;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h00};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r   = $urandom;
            ins = {r[31:7], ops[$urandom_range(0, 10)]};
            if ($urandom_range(0, 9) == 0) ins = $urandom;
            if ($urandom_range(0, 49) == 0) do_reset();
            cycle({$urandom} & 32'hFFFFFFFC, ins, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            d = ref_imm(m_instr[6:0]);
            vectors++;
            if ({id_instr, id_valid, id_stall_cycles} !== {m_instr, m_valid, CNT_W'(m_cnt)}) begin
                miscompares++;
                $display("FAIL rand_state[%0d]: got instr=%h valid=%b cnt=%0d, want %h %b %0d",
                         i, id_instr, id_valid, id_stall_cycles, m_instr, m_valid, m_cnt);
            end
            if (m_pc_known) begin
                vectors++;
                if ({id_pc, id_pc4} !== {m_pc, m_pc4}) begin
                    miscompares++;
                    $display("FAIL rand_pc[%0d]: got pc=%h pc4=%h, want %h %h", i, id_pc, id_pc4, m_pc, m_pc4);
                end
            end
            vectors++;
            if ({id_opcode, id_rd, id_rs1, id_rs2, id_funct3, id_immediate, id_imm_sel, id_has_imm, id_illegal}
                !== {m_instr[6:0], m_instr[11:7], m_instr[19:15], m_instr[24:20], m_instr[14:12],
                     m_instr[31:7], d[4:2], d[1], m_valid & ~d[0]}) begin
                miscompares++;
                $display("FAIL rand_decode[%0d]: instr=%h got sel=%b has=%b ill=%b, want sel=%b has=%b ill=%b",
                         i, m_instr, id_imm_sel, id_has_imm, id_illegal, d[4:2], d[1], m_valid & ~d[0]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = '0; if_instr = '0; if_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_store();
        test_stall();
        test_flush_stall();
        test_illegal();
        test_wrap();
        test_saturate();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
